// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI video timing controller.
// Holds the axis state enums, default 640x480 timing, coordinate widths and the colour-bar table.
package hdmi_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int RGB_W = 24;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // All three enums share one encoding so an axis segment code maps directly onto either view.
    typedef enum logic [1:0] {SEG_ACT, SEG_FP, SEG_SYNC, SEG_BP} seg_state_t;
    typedef enum logic [1:0] {H_ACT, H_FP, H_SYNC, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SYNC, V_BP} v_state_t;

    function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hdmi_timing_axis.sv
// One raster axis: wrapping counter plus ACTIVE/FP/SYNC/BP segment FSM.
// Used once for the horizontal axis (advance every pixel) and once for the vertical axis (advance per line).
module hdmi_timing_axis
    import hdmi_pkg::*;
#(
    parameter int   W        = 11,
    parameter int   ACTIVE   = 640,
    parameter int   FP       = 16,
    parameter int   SYNC     = 96,
    parameter int   BP       = 48,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic [1:0]   seg,
    output logic         wrap,
    output logic         sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST_ACT  = W'(ACTIVE - 1);
    localparam logic [W-1:0] LAST_FP   = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] LAST_SYNC = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

    if (TOTAL > (1 << W)) begin : g_total_too_wide
        $error("hdmi_timing_axis: timing total does not fit the counter width");
    end

    seg_state_t   state;
    seg_state_t   state_nxt;
    logic [W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEG_ACT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Segment boundaries are absolute counter values, so the FSM and counter stay locked together.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        if (adv) begin
            wrap    = (cnt == LAST);
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            case (state)
                SEG_ACT:  if (cnt == LAST_ACT)  state_nxt = SEG_FP;
                SEG_FP:   if (cnt == LAST_FP)   state_nxt = SEG_SYNC;
                SEG_SYNC: if (cnt == LAST_SYNC) state_nxt = SEG_BP;
                SEG_BP:   if (cnt == LAST)      state_nxt = SEG_ACT;
                default:  state_nxt = SEG_ACT;
            endcase
        end
    end

    assign seg  = state;
    assign sync = (state == SEG_SYNC) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// HDMI raster timing controller: pixel fetch handshake and TMDS encoder DE/data/control sequencing.
// Optional colour-bar generator enabled by defining HDMI_TIMING_TEST_PATTERN_EN.
module hdmi_timing_ctrl
    import hdmi_pkg::*;
#(
    parameter int               H_ACTIVE  = DEF_H_ACTIVE,
    parameter int               H_FP      = DEF_H_FP,
    parameter int               H_SYNC    = DEF_H_SYNC,
    parameter int               H_BP      = DEF_H_BP,
    parameter int               V_ACTIVE  = DEF_V_ACTIVE,
    parameter int               V_FP      = DEF_V_FP,
    parameter int               V_SYNC    = DEF_V_SYNC,
    parameter int               V_BP      = DEF_V_BP,
    parameter logic             HSYNC_POL = 1'b0,
    parameter logic             VSYNC_POL = 1'b0,
    parameter logic [RGB_W-1:0] BG_RGB    = 24'h000000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             pix_req,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             frame_start,
    input  logic             pix_valid,
    input  logic [RGB_W-1:0] pix_rgb,
    output logic             underflow,
    input  logic             underflow_clr,
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    input  logic             test_pattern,
`endif
    output logic             enc_de,
    output logic [7:0]       enc_d0,
    output logic [7:0]       enc_d1,
    output logic [7:0]       enc_d2,
    output logic             enc_c0_0,
    output logic             enc_c1_0,
    output logic             enc_c0_1,
    output logic             enc_c1_1,
    output logic             enc_c0_2,
    output logic             enc_c1_2
);

    logic           run;
    logic           at_origin;
    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic [1:0]     h_seg;
    logic [1:0]     v_seg;
    logic           h_wrap;
    logic           v_wrap;
    logic           h_sync;
    logic           v_sync;
    h_state_t       h_state;
    v_state_t       v_state;
    logic           active;

    logic           hs0, vs0;
    logic           req1, hs1, vs1;
    logic [RGB_W-1:0] rgb_nxt;
    logic           uf_set;
    logic           tp_sel;
    logic [RGB_W-1:0] tp_rgb;

    hdmi_timing_axis #(
        .W(X_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(HSYNC_POL)
    ) u_h_axis (
        .clk(clk), .reset_n(reset_n), .adv(run),
        .cnt(h_cnt), .seg(h_seg), .wrap(h_wrap), .sync(h_sync)
    );

    hdmi_timing_axis #(
        .W(Y_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(VSYNC_POL)
    ) u_v_axis (
        .clk(clk), .reset_n(reset_n), .adv(h_wrap),
        .cnt(v_cnt), .seg(v_seg), .wrap(v_wrap), .sync(v_sync)
    );

    assign h_state = h_state_t'(h_seg);
    assign v_state = v_state_t'(v_seg);
    assign active  = (h_state == H_ACT) && (v_state == V_ACT);

    // The raster holds at (0,0) for one cycle after reset release; at_origin tracks the (0,0) position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            at_origin <= 1'b1;
        end else begin
            run       <= 1'b1;
            at_origin <= run ? v_wrap : at_origin;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            hs0         <= ~HSYNC_POL;
            vs0         <= ~VSYNC_POL;
            req1        <= 1'b0;
            hs1         <= ~HSYNC_POL;
            vs1         <= ~VSYNC_POL;
        end else begin
            pix_req     <= run & active;
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            frame_start <= run & at_origin;
            hs0         <= h_sync;
            vs0         <= v_sync;
            req1        <= pix_req;
            hs1         <= hs0;
            vs1         <= vs0;
        end
    end

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam logic [X_W-1:0] BAR_W_V = X_W'(BAR_W);

    logic [X_W-1:0] x1;
    logic [X_W-1:0] bar_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) x1 <= '0;
        else          x1 <= pix_x;
    end

    assign bar_q  = x1 / BAR_W_V;
    assign tp_sel = test_pattern;
    assign tp_rgb = bar_rgb((bar_q > X_W'(7)) ? 3'd7 : bar_q[2:0]);
`else
    assign tp_sel = 1'b0;
    assign tp_rgb = '0;
`endif

    // Data stage: a missing pixel is replaced by the background colour and flagged.
    always_comb begin
        rgb_nxt = '0;
        uf_set  = 1'b0;
        if (req1) begin
            if (tp_sel) begin
                rgb_nxt = tp_rgb;
            end else if (pix_valid) begin
                rgb_nxt = pix_rgb;
            end else begin
                rgb_nxt = BG_RGB;
                uf_set  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enc_de    <= 1'b0;
            enc_d0    <= '0;
            enc_d1    <= '0;
            enc_d2    <= '0;
            enc_c0_0  <= ~HSYNC_POL;
            enc_c1_0  <= ~VSYNC_POL;
            underflow <= 1'b0;
        end else begin
            enc_de    <= req1;
            enc_d2    <= rgb_nxt[23:16];
            enc_d1    <= rgb_nxt[15:8];
            enc_d0    <= rgb_nxt[7:0];
            enc_c0_0  <= hs1;
            enc_c1_0  <= vs1;
            underflow <= (underflow & ~underflow_clr) | uf_set;
        end
    end

    assign enc_c0_1 = 1'b0;
    assign enc_c1_1 = 1'b0;
    assign enc_c0_2 = 1'b0;
    assign enc_c1_2 = 1'b0;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Randomized bench for hdmi_timing_ctrl on a reduced raster, checked against a position-arithmetic model.
// Exercises the colour-bar path as well when HDMI_TIMING_TEST_PATTERN_EN is defined.
module tb_hdmi_timing_ctrl;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;
    localparam logic [23:0] BG = 24'h3C5A96;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_req, frame_start, pix_valid, underflow, underflow_clr;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        enc_de, enc_c0_0, enc_c1_0, enc_c0_1, enc_c1_1, enc_c0_2, enc_c1_2;
    logic [7:0]  enc_d0, enc_d1, enc_d2;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    logic        test_pattern;
`endif

    int checksTotal = 0;
    int checksPassed = 0;
    int cyc = -1;
    logic        ufModel = 1'b0;
    logic        drvValid [MAXC];
    logic [23:0] drvRgb   [MAXC];
    logic        drvClr   [MAXC];
    logic        drvTp    [MAXC];
    logic [23:0] barTable [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    hdmi_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .BG_RGB(BG)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .underflow(underflow), .underflow_clr(underflow_clr),
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .enc_de(enc_de), .enc_d0(enc_d0), .enc_d1(enc_d1), .enc_d2(enc_d2),
        .enc_c0_0(enc_c0_0), .enc_c1_0(enc_c1_0), .enc_c0_1(enc_c0_1),
        .enc_c1_1(enc_c1_1), .enc_c0_2(enc_c0_2), .enc_c1_2(enc_c1_2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    endtask

    function automatic logic isActive(input int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic logic hsLevel(input int p);
        int x = p % HT;
        return (x >= HA + HFP && x < HA + HFP + HS) ? HPOL : ~HPOL;
    endfunction

    function automatic logic vsLevel(input int p);
        int y = p / HT;
        return (y >= VA + VFP && y < VA + VFP + VS) ? VPOL : ~VPOL;
    endfunction

    function automatic int barIndex(input int x);
        int b = x / (HA / 8);
        return (b > 7) ? 7 : b;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, {63'd0, pix_req}, 64'd0);
        checkOutput({tag, "_xy"}, {43'd0, pix_x, pix_y}, 64'd0);
        checkOutput({tag, "_fs"}, {63'd0, frame_start}, 64'd0);
        checkOutput({tag, "_de"}, {63'd0, enc_de}, 64'd0);
        checkOutput({tag, "_data"}, {40'd0, enc_d2, enc_d1, enc_d0}, 64'd0);
        checkOutput({tag, "_ctl"}, {58'd0, enc_c0_0, enc_c1_0, enc_c0_1, enc_c1_1, enc_c0_2, enc_c1_2},
                    {58'd0, ~HPOL, ~VPOL, 4'b0000});
        checkOutput({tag, "_uf"}, {63'd0, underflow}, 64'd0);
    endtask

    // Expected outputs for the current cycle derived purely from the raster position and the driven inputs.
    task automatic applyCycleChecks();
        int p, q;
        logic eReq, eFs, eDe, eHs, eVs;
        logic [20:0] eXY;
        logic [23:0] eRgb;
        eReq = 1'b0; eFs = 1'b0; eDe = 1'b0; eHs = ~HPOL; eVs = ~VPOL;
        eXY = '0; eRgb = '0;
        if (cyc >= 1) begin
            p    = (cyc - 1) % FR;
            eReq = isActive(p);
            eXY  = {11'(p % HT), 10'(p / HT)};
            eFs  = (p == 0);
        end
        if (cyc >= 3) begin
            q   = (cyc - 3) % FR;
            eDe = isActive(q);
            eHs = hsLevel(q);
            eVs = vsLevel(q);
            if (eDe) begin
                if (drvTp[cyc-1])         eRgb = barTable[barIndex(q % HT)];
                else if (drvValid[cyc-1]) eRgb = drvRgb[cyc-1];
                else                      eRgb = BG;
            end
        end
        if (cyc >= 1)
            ufModel = (ufModel & ~drvClr[cyc-1]) | (eDe & ~drvTp[cyc-1] & ~drvValid[cyc-1]);
        checkOutput("req", {63'd0, pix_req}, {63'd0, eReq});
        checkOutput("xy", {43'd0, pix_x, pix_y}, {43'd0, eXY});
        checkOutput("frame_start", {63'd0, frame_start}, {63'd0, eFs});
        checkOutput("de", {63'd0, enc_de}, {63'd0, eDe});
        checkOutput("data", {40'd0, enc_d2, enc_d1, enc_d0}, {40'd0, eRgb});
        checkOutput("ctl", {58'd0, enc_c0_0, enc_c1_0, enc_c0_1, enc_c1_1, enc_c0_2, enc_c1_2},
                    {58'd0, eHs, eVs, 4'b0000});
        checkOutput("underflow", {63'd0, underflow}, {63'd0, ufModel});
    endtask

    // mode 0: valid always (one dropped pixel at (5,3), later a clear); 1: random; 2: random test pattern
    task automatic applyStimulus(input int mode);
        int t;
        logic v, c, tp;
        logic [23:0] rgb;
        t   = (cyc >= 2) ? (cyc - 2) : 0;
        v   = 1'b1; c = 1'b0; tp = 1'b0;
        rgb = {8'(t % FR / HT), 8'(t % HT), 8'hA5};
        if (mode == 0) begin
            if (cyc >= 2 && t < FR && t == 3 * HT + 5) v = 1'b0;
            if (cyc == FR + 50) c = 1'b1;
        end else if (mode == 1) begin
            v   = ($urandom % 8) != 0;
            c   = ($urandom % 32) == 0;
            rgb = 24'($urandom);
        end else begin
            tp  = ($urandom % 4) != 0;
            v   = ($urandom % 2) != 0;
            c   = ($urandom % 64) == 0;
            rgb = 24'($urandom);
        end
        drvValid[cyc] = v;
        drvRgb[cyc]   = rgb;
        drvClr[cyc]   = c;
        drvTp[cyc]    = tp;
        pix_valid     = v;
        pix_rgb       = rgb;
        underflow_clr = c;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        test_pattern  = tp;
`endif
    endtask

    task automatic stepCycle(input int mode);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exceeded");
        end
        applyCycleChecks();
        applyStimulus(mode);
    endtask

    task automatic runSegment(input int n, input int mode);
        for (int i = 0; i < n; i++) stepCycle(mode);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = -1;
        ufModel = 1'b0;
    endtask

    initial begin
        logic hit;
        pix_valid = 1'b0;
        pix_rgb = '0;
        underflow_clr = 1'b0;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        test_pattern = 1'b0;
`endif
        #12;
        checkResetValues("por");
        releaseReset();

        runSegment(2 * FR + 40, 0);
        runSegment(900, 1);

        // Run to the request for line 3 pixel 10, then pull reset mid-cycle.
        hit = 1'b0;
        for (int i = 0; i <= FR + 1 && !hit; i++) begin
            stepCycle(1);
            hit = (cyc >= 1) && ((cyc - 1) % FR == 3 * HT + 10);
        end
        checkOutput("mid_reset_reached", {63'd0, hit}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("held_rst");
        releaseReset();

        runSegment(FR + 30, 1);
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        runSegment(2 * FR, 2);
`endif
        runSegment(20, 0);

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_ctrl.md
# hdmi_timing_ctrl

Video timing controller that sequences the three TMDS channel encoders of the HDMI output path. It runs the horizontal/vertical raster, fetches active pixels from the spectrometer display line buffer through a request/valid handshake, and drives each encoder's data-enable, 8-bit data and C0/C1 control inputs. Sync is carried on the blue channel (C0 = HSYNC, C1 = VSYNC); green/red control lines are held 0.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (each ≥1)
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines (each ≥1)
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted sync level (0 = active low)
- BG_RGB, 24'h000000, colour substituted on underflow
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- pix_req  out  1  request for pixel (pix_x, pix_y)
- pix_x  out  11  requested column
- pix_y  out  10  requested row
- frame_start  out  1  one-cycle pulse with the request for (0,0)
- pix_valid  in  1  pix_rgb valid, exactly one cycle after pix_req
- pix_rgb  in  24  {R,G,B} pixel
- underflow  out  1  sticky: pix_valid low when required
- underflow_clr  in  1  clears underflow
- enc_de  out  1  DE to all three encoders
- enc_d0 / enc_d1 / enc_d2  out  8 each  blue / green / red data
- enc_c0_0 / enc_c1_0  out  1 each  blue-channel C0 (HSYNC), C1 (VSYNC)
- enc_c0_1, enc_c1_1, enc_c0_2, enc_c1_2  out  1 each  held 0

## Operation
- h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params); v_cnt 0..V_TOTAL-1; v_cnt increments when h_cnt wraps; both wrap to 0.
- Horizontal FSM H_ACT → H_FP → H_SYNC → H_BP → H_ACT; vertical FSM V_ACT → V_FP → V_SYNC → V_BP → V_ACT, advancing on line wrap. Active region starts at count 0.
- Active = H_ACT and V_ACT. HSYNC asserted in H_SYNC on every line; VSYNC asserted for all of V_SYNC lines, transitions aligned to h_cnt = 0.
- pix_req = active; pix_x/pix_y = counters; frame_start when h_cnt = v_cnt = 0.
- At the data stage: if pix_valid, enc_d2/d1/d0 = pix_rgb[23:16]/[15:8]/[7:0]; else BG_RGB components and underflow set. pix_valid while no request outstanding is ignored.
- underflow_clr and a new underflow in the same cycle: underflow stays 1.
- During blanking enc_d* = 0.
- Counter widths: h_cnt 11 bits, v_cnt 10 bits; parameter totals must fit.

## Timing
- Reset (async assert, sync release): counters 0, FSMs H_ACT/V_ACT, pix_req/frame_start/enc_de/enc_d*/underflow 0, pix_x/pix_y 0, enc_c0_0 = ~HSYNC_POL, enc_c1_0 = ~VSYNC_POL, other control lines 0.
- Cycle 0 = first clk edge after release: counters at (0,0). pix_req/pix_x/pix_y/frame_start are registered: high in cycle 1 for position (0,0).
- pix_valid/pix_rgb sampled in the cycle after pix_req (cycle N+1 for request in N).
- enc_de, enc_d*, enc_c* registered and mutually aligned: valid in cycle N+2 for a request in cycle N (sync/DE pipelined to match).
- Reset mid-frame: all outputs return to reset values immediately; in-flight requests discarded; raster restarts at (0,0).

## Configuration
- HDMI_TIMING_TEST_PATTERN_EN defined: adds input test_pattern (1 bit). When 1 at the data stage, pix_rgb/pix_valid are ignored, underflow is not set, and 8 vertical colour bars of H_ACTIVE/8 pixels (white, yellow, cyan, green, magenta, red, blue, black) are output. pix_req still toggles.
- Undefined: no test_pattern port; data always from pix_rgb/BG_RGB.

## Structure
- Package hdmi_pkg: horizontal/vertical state enums, default 640×480 timing constants, colour-bar table, pixel/coordinate widths.
- One sub-module: hdmi_timing_axis, instantiated twice (horizontal, vertical) — generic counter + 4-state FSM with ACTIVE/FP/SYNC/BP lengths, advance enable, wrap strobe and sync output.

## Test plan
- Release reset, run 2 frames with pix_valid always 1 → pix_req high 640 cycles per line, 480 lines; line period 800, frame period 525×800 = 420000 cycles; frame_start every 420000.
- Check sync: HSYNC low for h_cnt 656..751 (96 cycles) each line; VSYNC low for lines 490..491 exactly, edges at h_cnt 0; DE never overlaps either.
- Return pix_rgb = {y[7:0], x[7:0], 8'hA5} → enc_d2/d1/d0 match at request+2, aligned with enc_de.
- Drop pix_valid for pixel (5,3) → that pixel BG_RGB, underflow = 1 and stays; underflow_clr pulse → 0.
- Assert reset_n low at line 200, pixel 300, for 3 cycles → outputs at reset values asynchronously; after release first request is (0,0) with frame_start.
- With HDMI_TIMING_TEST_PATTERN_EN, test_pattern = 1 → pixel 0 = FFFFFF, pixel 80 = FFFF00, pixel 639 = 000000; underflow stays 0 with pix_valid = 0.
